// File: rtl/top.sv
// SPI slave register block (CPOL=0, CPHA=0, LSB first) for the Pmod JC header.
// SCK/SS/MOSI are oversampled by the system clock; nothing is clocked by SCK.
module top #(
  parameter logic [7:0] CHIP_ID     = 8'h07,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK100MHZ,
  input  logic        btnC,
  input  logic [15:0] sw,
  output logic [15:0] LED,
  inout  wire  [7:0]  JC
);

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sck_prev_r;

  logic [2:0]  bit_cnt_r;
  logic        byte_b_r;
  logic [7:0]  rx_sh_r;
  logic [7:0]  tx_sh_r;
  logic [7:0]  cmd_r;
  logic        miso_r;
  logic [15:0] led_r;

  logic        sck_s;
  logic        ss_s;
  logic        mosi_s;
  logic        rise_s;
  logic        fall_s;
  logic [7:0]  rx_next_s;
  logic [7:0]  rd_data_s;

  function automatic logic [7:0] read_reg(input logic [3:0]  addr,
                                          input logic [15:0] sw_v,
                                          input logic [15:0] led_v);
    logic [7:0] data;
    case (addr)
      4'd0:    data = CHIP_ID;
      4'd1:    data = sw_v[7:0];
      4'd2:    data = sw_v[15:8];
      4'd3:    data = led_v[7:0];
      4'd4:    data = led_v[15:8];
      default: data = 8'h00;
    endcase
    return data;
  endfunction

  // Only MISO is driven; the rest of the header stays high-Z.
  assign JC  = {1'bz, 1'bz, miso_r, 1'bz, 4'bzzzz};
  assign LED = led_r;

  // Synchronizers idle at SCK=0, SS=1 (deselected), MOSI=0.
  always_ff @(posedge CLK100MHZ or negedge btnC) begin
    if (!btnC) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_prev_r  <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], JC[6]};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], JC[7]};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], JC[4]};
      sck_prev_r  <= sck_s;
    end
  end

  // Synchronized pins, SCK edge pulses and the register read mux.
  always_comb begin
    sck_s     = sck_sync_r[SYNC_STAGES-1];
    ss_s      = ss_sync_r[SYNC_STAGES-1];
    mosi_s    = mosi_sync_r[SYNC_STAGES-1];
    rise_s    = sck_s & ~sck_prev_r;
    fall_s    = ~sck_s & sck_prev_r;
    rx_next_s = {mosi_s, rx_sh_r[7:1]};
    rd_data_s = read_reg(rx_next_s[3:0], sw, led_r);
  end

  // Frame engine: byte A is the command, byte B the data; SS high aborts.
  always_ff @(posedge CLK100MHZ or negedge btnC) begin
    if (!btnC) begin
      bit_cnt_r <= 3'd0;
      byte_b_r  <= 1'b0;
      rx_sh_r   <= 8'h00;
      tx_sh_r   <= 8'h00;
      cmd_r     <= 8'h00;
      miso_r    <= 1'b0;
      led_r     <= 16'h0000;
    end else if (ss_s) begin
      bit_cnt_r <= 3'd0;
      byte_b_r  <= 1'b0;
      rx_sh_r   <= 8'h00;
      tx_sh_r   <= 8'h00;
      miso_r    <= 1'b0;
    end else if (rise_s) begin
      rx_sh_r   <= rx_next_s;
      bit_cnt_r <= bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        byte_b_r <= ~byte_b_r;
        if (!byte_b_r) begin
          // Command complete: present bit0 of the response before byte B starts.
          cmd_r   <= rx_next_s;
          tx_sh_r <= rd_data_s;
          miso_r  <= rd_data_s[0];
        end else begin
          miso_r <= 1'b0;
          if (cmd_r[7]) begin
            case (cmd_r[3:0])
              4'd3:    led_r[7:0]  <= rx_next_s;
              4'd4:    led_r[15:8] <= rx_next_s;
              default: led_r       <= led_r;
            endcase
          end else begin
            led_r <= led_r;
          end
        end
      end else begin
        byte_b_r <= byte_b_r;
      end
    end else if (fall_s && byte_b_r && (bit_cnt_r != 3'd0)) begin
      // The fall that closes byte A has bit_cnt 0 and must not consume bit0.
      tx_sh_r <= {1'b0, tx_sh_r[7:1]};
      miso_r  <= tx_sh_r[1];
    end else begin
      miso_r <= miso_r;
    end
  end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the SPI slave register block: the driver pushes expectations,
// a monitor pops and compares whenever an observation is presented.
module tb_top;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        btn_c;
  logic [15:0] sw;
  wire  [15:0] led;
  wire  [7:0]  jc;
  logic        mosi;
  logic        sck;
  logic        ss;
  wire         miso;

  always #5 clk = ~clk;

  assign jc   = {ss, sck, 1'bz, mosi, 4'bzzzz};
  assign miso = jc[5];

  top dut (
    .CLK100MHZ(clk),
    .btnC     (btn_c),
    .sw       (sw),
    .LED      (led),
    .JC       (jc)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } item_t;

  item_t       exp_q[$];
  int          total  = 0;
  int          passed = 0;
  event        obs_ev;
  logic [1:0]  obs_kind;
  logic [15:0] obs_val;

  function automatic string kname(input logic [1:0] k);
    case (k)
      2'd0:    return "rx_byte_a";
      2'd1:    return "rx_byte_b";
      2'd2:    return "led";
      default: return "miso_pin";
    endcase
  endfunction

  // Monitor: compares every presented observation with the oldest expectation.
  initial begin : monitor
    item_t e;
    forever begin
      @(obs_ev);
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow %s got=%h", kname(obs_kind), obs_val);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == obs_kind && e.val == obs_val) passed++;
        else $display("FAIL %s got=%h (kind %0d) expected=%h (kind %0d)",
                      kname(e.kind), obs_val, obs_kind, e.val, e.kind);
      end
    end
  end

  task automatic push_exp(input logic [1:0] k, input logic [15:0] v);
    item_t it;
    it.kind = k;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input logic [1:0] k, input logic [15:0] v);
    obs_kind = k;
    obs_val  = v;
    -> obs_ev;
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[i];
      repeat (HALF) @(posedge clk);
      #1;
      rx[i] = miso;
      sck = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      sck = 1'b0;
    end
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_b);
    logic [7:0] r;
    push_exp(2'd0, 16'h0000);
    push_exp(2'd1, {8'h00, exp_b});
    spi_bits(a, 8, r);
    observe(2'd0, {8'h00, r});
    spi_bits(b, 8, r);
    observe(2'd1, {8'h00, r});
  endtask

  task automatic check_led(input logic [15:0] v);
    push_exp(2'd2, v);
    repeat (6) @(posedge clk);
    #1;
    observe(2'd2, led);
  endtask

  task automatic check_miso(input logic v);
    push_exp(2'd3, {15'h0000, v});
    observe(2'd3, {15'h0000, miso});
  endtask

  initial begin : driver
    logic [7:0] r;
    btn_c = 1'b0;
    ss    = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b0;
    sw    = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    check_miso(1'b0);
    check_led(16'h0000);
    btn_c = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ss = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    pair(8'h00, 8'h00, 8'h07);
    pair(8'h00, 8'h00, 8'h07);

    sw = 16'h00FF;
    repeat (4) @(posedge clk);
    pair(8'h01, 8'h01, 8'hFF);
    pair(8'h02, 8'h02, 8'h00);

    check_led(16'h0000);
    pair(8'hF3, 8'hFF, 8'h00);
    check_led(16'h00FF);
    pair(8'hF4, 8'hAA, 8'h00);
    check_led(16'hAAFF);

    pair(8'h03, 8'h03, 8'hFF);
    pair(8'h04, 8'h04, 8'hAA);

    // Abort a write after 3 data bits: no LED change, next frame starts at byte A.
    push_exp(2'd0, 16'h0000);
    spi_bits(8'hF3, 8, r);
    observe(2'd0, {8'h00, r});
    spi_bits(8'h00, 3, r);
    ss = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_miso(1'b0);
    ss = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    pair(8'h00, 8'h00, 8'h07);
    check_led(16'hAAFF);

    // A write pair still returns the old register contents.
    pair(8'hF3, 8'h00, 8'hFF);
    pair(8'hF4, 8'h00, 8'hAA);
    check_led(16'h0000);

    pair(8'h09, 8'h00, 8'h00);
    sw = 16'hA5C3;
    repeat (4) @(posedge clk);
    pair(8'h02, 8'h00, 8'hA5);
    pair(8'h01, 8'h00, 8'hC3);

    // Reset in the middle of byte B while MISO is high.
    pair(8'hF3, 8'h5A, 8'h00);
    check_led(16'h005A);
    push_exp(2'd0, 16'h0000);
    spi_bits(8'h00, 8, r);
    observe(2'd0, {8'h00, r});
    spi_bits(8'h00, 1, r);
    repeat (5) @(posedge clk);
    #1;
    check_miso(1'b1);
    btn_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_miso(1'b0);
    check_led(16'h0000);
    btn_c = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pair(8'h00, 8'h00, 8'h07);

    ss = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- FPGA top-level SPI slave register block. An external SPI master on the Pmod JC header reads a chip ID, the 16 slide switches and the 16 LEDs, and writes the LEDs.
- All SPI inputs are oversampled by the 100 MHz system clock; no logic is clocked by SCK.

Parameters:
- CHIP_ID, 8'h07, value returned by register 0.
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on SCK, SS and MOSI.

Ports:
- CLK100MHZ  input  1  system clock.
- btnC  input  1  reset, asynchronous, active-low.
- sw  input  16  slide switches.
- LED  output  16  LED register.
- JC  inout  8  Pmod header:
  - JC[4] MOSI (input).
  - JC[5] MISO (output).
  - JC[6] SCK (input).
  - JC[7] SS (input, active-low).
  - JC[3:0] high-Z, unused.

Behaviour:
- Reset (btnC=0):
  - LED=16'h0000; MISO=0.
  - Bit counter, byte counter and shift registers cleared.
  - All synchronizers reset to idle: SCK=0, SS=1, MOSI=0.
- Input conditioning:
  - SCK, SS and MOSI each pass through a SYNC_STAGES synchronizer.
  - SCK rise and fall are detected as single-cycle pulses.
- SPI mode:
  - CPOL=0, CPHA=0, LSB first.
  - MOSI is sampled on the synchronized SCK rising edge.
  - The master samples MISO at its own SCK rising edge, so MISO must be stable before each rise.
- Frame:
  - SS high: bit/byte counters reset, frame aborted, no write, MISO driven 0.
  - SS low: bytes are grouped in pairs, byte A = command, byte B = data. The pair counter toggles after every 8th rising edge.
- Command byte A:
  - cmd[7]=1 means write; cmd[7]=0 means read.
  - cmd[3:0] = register address; cmd[6:4] ignored.
- Register map:
  - 0: CHIP_ID, read-only.
  - 1: sw[7:0], read-only.
  - 2: sw[15:8], read-only.
  - 3: LED[7:0], read/write.
  - 4: LED[15:8], read/write.
  - Other addresses read 8'h00; writes to them are ignored.
- Response:
  - Within 4 clocks after the 8th rising edge of byte A, the selected register value is loaded into the TX shift register and bit0 is driven on MISO.
  - Each subsequent SCK falling edge during byte B shifts to the next bit, LSB first.
  - Switches are captured at load time.
  - During byte A, MISO drives 0.
- Write:
  - On the 8th rising edge of byte B with cmd[7]=1, the received byte is written to the addressed LED half.
  - LED updates within 4 clocks of that edge.
  - Byte B of a write still shifts out the old register value.
- Read: byte B content is ignored.
- Frame boundaries:
  - Consecutive pairs may follow back-to-back without SS toggling.
  - Releasing SS mid-byte discards the partial byte and returns to byte A.
- Reset mid-frame: same as SS release plus LED clear.
- Timing: supports SCK half-periods down to 8 system clocks.

Test Plan:
- Reset, then SS low; send 0x00,0x00 twice -> second byte of each pair returns 0x07.
- sw=16'h00FF; send pair 0x01,0x01 -> returns 0xFF. Send pair 0x02,0x02 -> returns 0x00.
- LED writes:
  - After reset LED=0x0000.
  - Send 0xF3,0xFF -> LED=0x00FF.
  - Send 0xF4,0xAA -> LED=0xAAFF.
- Send 0x03,0x03 -> returns 0xFF. Send 0x04,0x04 -> returns 0xAA. Send 0xF3,0x00 and 0xF4,0x00 -> LED=0x0000.
- Raise SS after 3 bits of a write data byte, then send 0x00,0x00 -> LED unchanged, returns 0x07.
- Read address 0x9 -> 0x00. Assert reset mid-byte -> LED=0, MISO=0, next frame starts at byte A.
